aip_sequencer: RTL and testbench
================================

# aip_sequencer

Autonomous sequencer for one AIP core: runs a full load, configure, start, wait and drain transaction on the AIP port (dataIn/config/read/write/start/int) without per-word CPU accesses. It sits between a host-side command and stream interface (driven by a DMA or Nios-side FIFO logic) and the AIP core. It replaces the word-by-word register bridge when a bulk transfer is needed.

## Interface
Parameters:
- `LEN_W`, 8: width of the word counters; max burst is 2^LEN_W-1 words.
- `TIMEOUT_CYC`, 65535: WAIT-state cycle limit, ≥2.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_cmd_valid`  in  1  command request.
- `o_cmd_ready`  out  1  high only in IDLE.
- `i_cmd_in_len`  in  LEN_W  words to write to the AIP.
- `i_cmd_out_len`  in  LEN_W  words to read from the AIP.
- `i_cmd_in_cfg`  in  5  config code for the input memory.
- `i_cmd_out_cfg`  in  5  config code for the output memory.
- `i_wr_data`  in  32  input stream data.
- `i_wr_valid`  in  1  input stream valid.
- `o_wr_ready`  out  1  input stream ready.
- `o_rd_data`  out  32  output stream data (= `i_aip_dataOut`).
- `o_rd_valid`  out  1  output stream valid.
- `i_rd_ready`  in  1  output stream ready.
- `o_busy`  out  1  state != IDLE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_timeout`  out  1  sticky; last command timed out.
- `o_aip_dataIn`  out  32  registered write data.
- `o_aip_config`  out  5  registered config code.
- `o_aip_write`  out  1  one-cycle write pulse per word.
- `o_aip_read`  out  1  read/advance strobe.
- `o_aip_start`  out  1  one-cycle start pulse.
- `i_aip_dataOut`  in  32  AIP current output word.
- `i_aip_int`  in  1  AIP done, level.

## Operation
- States: IDLE, CFG_IN, LOAD, START, WAIT, CFG_OUT, SETTLE, DRAIN, DONE.
- IDLE:
  - On `i_cmd_valid && o_cmd_ready`, latch lengths and configs.
  - Clear `o_timeout`.
  - Go to CFG_IN.
  - `i_cmd_valid` outside IDLE is ignored.
- CFG_IN:
  - Drive `o_aip_config`=in_cfg.
  - Go to LOAD, or to START if in_len=0.
- LOAD:
  - `o_wr_ready`=1.
  - Each handshake registers `o_aip_dataIn`=`i_wr_data` and asserts `o_aip_write` for exactly the next cycle.
  - Word counter increments per handshake.
  - After handshake number in_len, go to START.
  - A `i_wr_valid` gap produces no write.
- START:
  - `o_aip_start` registered high for exactly the next cycle.
  - Go to WAIT.
- WAIT:
  - Timeout counter starts at 0 and increments per cycle.
  - `i_aip_int`=1 → CFG_OUT.
  - If the counter reaches TIMEOUT_CYC-1 without int: set `o_timeout`, go to DONE with no drain.
- CFG_OUT:
  - Drive `o_aip_config`=out_cfg.
  - Go to SETTLE, a single cycle that allows `i_aip_dataOut` to settle.
  - Then go to DRAIN, or to DONE if out_len=0.
- DRAIN:
  - `o_rd_valid`=1; `o_rd_data`=`i_aip_dataOut` (combinational).
  - `o_aip_read`=`i_rd_ready`, combinational; each high cycle consumes one word.
  - After read number out_len, go to DONE.
- DONE:
  - `o_done` asserted for this single cycle.
  - Go to IDLE.
- `o_aip_config` holds its last value through IDLE.
- Counters are LEN_W bits. Length compare uses equality, so there is no wrap.

## Timing
- Reset value of every output is 0: all AIP outputs, `o_done`, `o_timeout`, `o_busy`, `o_wr_ready`, `o_rd_valid`, `o_rd_data`=dataOut passthrough.
- `o_cmd_ready`=1 from the first cycle after reset.
- Reset mid-transaction:
  - The state returns to IDLE at the next edge.
  - No further write, start or read pulse occurs.
  - Counters clear.
- Command accepted at edge T: CFG_IN during T+1; LOAD from T+2.
- Last write handshake at cycle k: `o_aip_write` high at k+1, `o_aip_start` high at k+2 (never coincident).
- With in_len=0, `o_aip_start` is high at T+3.
- WAIT begins the cycle after the start pulse, so `i_aip_int` high during the start pulse cycle is not sampled.
- `i_aip_int` sampled high at cycle w: config changes at w+2; first `o_rd_valid` at w+3.
- `o_done` occurs one cycle after the last read; `o_cmd_ready` rises the cycle after `o_done`.

## Test plan
- Nominal: in_len=3 (data 0xA1,0xA2,0xA3), out_len=2, in_cfg=1, out_cfg=2, int 5 cycles after start, dataOut 0xB1 then 0xB2.
  - Expect config=1, then three write pulses with matching dataIn.
  - Start pulse one cycle after the third write.
  - Config=2, then `o_rd_data` 0xB1 and 0xB2 with two `o_aip_read` pulses, then one `o_done` and `o_timeout`=0.
- Backpressure: `i_wr_valid` toggled 1,0,1,0,1 and `i_rd_ready` held 0 for 4 DRAIN cycles.
  - Exactly in_len writes and no `o_aip_read` while ready=0.
  - `o_rd_valid` stays 1 and the word is not lost.
- Zero lengths: in_len=0, out_len=0.
  - Expect config, a start pulse at T+3, wait for int, then `o_done`.
  - Zero `o_aip_write` and zero `o_aip_read`.
- Timeout: TIMEOUT_CYC=16, int held 0.
  - `o_done` and `o_timeout`=1 at 16 cycles after WAIT entry, with no reads.
  - `o_timeout` clears on the next command accept.
- Reset mid-LOAD after 1 of 3 words: all outputs 0 next cycle, `o_cmd_ready`=1, no start pulse ever issued.
- Ignored inputs:
  - `i_cmd_valid` held during busy: no second command until after `o_done`.
  - int=1 during the start-pulse cycle only: not treated as done, so WAIT continues.

Source files
------------

// File: rtl/aip_sequencer_if.sv
// Port bundle for aip_sequencer: host command, write/read streams and the AIP core port.
// The slave modport is the sequencer's view; master is the environment that
// issues commands, feeds/consumes the streams and plays the AIP core.
interface aip_sequencer_if #(
  parameter int LEN_W = 8
);

  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [LEN_W-1:0] i_cmd_in_len;
  logic [LEN_W-1:0] i_cmd_out_len;
  logic [4:0]       i_cmd_in_cfg;
  logic [4:0]       i_cmd_out_cfg;

  logic [31:0]      i_wr_data;
  logic             i_wr_valid;
  logic             o_wr_ready;

  logic [31:0]      o_rd_data;
  logic             o_rd_valid;
  logic             i_rd_ready;

  logic             o_busy;
  logic             o_done;
  logic             o_timeout;

  logic [31:0]      o_aip_dataIn;
  logic [4:0]       o_aip_config;
  logic             o_aip_write;
  logic             o_aip_read;
  logic             o_aip_start;
  logic [31:0]      i_aip_dataOut;
  logic             i_aip_int;

  modport slave (
    input  i_cmd_valid, i_cmd_in_len, i_cmd_out_len, i_cmd_in_cfg, i_cmd_out_cfg,
    input  i_wr_data, i_wr_valid, i_rd_ready, i_aip_dataOut, i_aip_int,
    output o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid,
    output o_busy, o_done, o_timeout,
    output o_aip_dataIn, o_aip_config, o_aip_write, o_aip_read, o_aip_start
  );

  modport master (
    output i_cmd_valid, i_cmd_in_len, i_cmd_out_len, i_cmd_in_cfg, i_cmd_out_cfg,
    output i_wr_data, i_wr_valid, i_rd_ready, i_aip_dataOut, i_aip_int,
    input  o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid,
    input  o_busy, o_done, o_timeout,
    input  o_aip_dataIn, o_aip_config, o_aip_write, o_aip_read, o_aip_start
  );

endinterface

// File: rtl/aip_sequencer.sv
// aip_sequencer: runs one complete load / configure / start / wait / drain
// transaction on an AIP core from a single host command, so bulk transfers
// need no word-by-word CPU register accesses.
module aip_sequencer #(
  parameter int LEN_W       = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic           i_clk,
  input  logic           i_rst,
  aip_sequencer_if.slave bus
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CFG_IN  = 4'd1;
  localparam logic [3:0] S_LOAD    = 4'd2;
  localparam logic [3:0] S_START   = 4'd3;
  localparam logic [3:0] S_WAIT    = 4'd4;
  localparam logic [3:0] S_CFG_OUT = 4'd5;
  localparam logic [3:0] S_SETTLE  = 4'd6;
  localparam logic [3:0] S_DRAIN   = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]       state;
  logic [LEN_W-1:0] in_len;
  logic [LEN_W-1:0] out_len;
  logic [4:0]       in_cfg;
  logic [4:0]       out_cfg;
  logic [LEN_W-1:0] wr_cnt;
  logic [LEN_W-1:0] rd_cnt;
  logic [TO_W-1:0]  to_cnt;

  logic [31:0]      aip_data_in;
  logic [4:0]       aip_config;
  logic             aip_write;
  logic             aip_start;
  logic             timeout_flag;

  logic             cmd_accept;
  logic             wr_hs;
  logic             rd_hs;
  logic             wr_last;
  logic             rd_last;
  logic             to_expire;

  // Handshake qualifiers and end-of-burst detection; lengths are compared
  // for equality against the post-increment count, so counters never wrap.
  assign cmd_accept = (state == S_IDLE) && bus.i_cmd_valid;
  assign wr_hs      = (state == S_LOAD) && bus.i_wr_valid;
  assign rd_hs      = (state == S_DRAIN) && bus.i_rd_ready;
  assign wr_last    = ((wr_cnt + LEN_W'(1)) == in_len);
  assign rd_last    = ((rd_cnt + LEN_W'(1)) == out_len);
  assign to_expire  = (state == S_WAIT) && !bus.i_aip_int && (to_cnt == TO_LAST);

  // Transaction FSM with command latches and word/timeout counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      in_len  <= '0;
      out_len <= '0;
      in_cfg  <= '0;
      out_cfg <= '0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      to_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_accept) begin
            in_len  <= bus.i_cmd_in_len;
            out_len <= bus.i_cmd_out_len;
            in_cfg  <= bus.i_cmd_in_cfg;
            out_cfg <= bus.i_cmd_out_cfg;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            to_cnt  <= '0;
            state   <= S_CFG_IN;
          end
        end
        S_CFG_IN: begin
          state <= (in_len == '0) ? S_START : S_LOAD;
        end
        S_LOAD: begin
          if (wr_hs) begin
            wr_cnt <= wr_cnt + LEN_W'(1);
            if (wr_last) begin
              state <= S_START;
            end
          end
        end
        S_START: begin
          // START spans the cycle that requests the pulse and the pulse
          // cycle itself, so int during the pulse is never sampled.
          if (aip_start) begin
            to_cnt <= '0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.i_aip_int) begin
            state <= S_CFG_OUT;
          end else if (to_cnt == TO_LAST) begin
            state <= S_DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        S_CFG_OUT: begin
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          state <= (out_len == '0) ? S_DONE : S_DRAIN;
        end
        S_DRAIN: begin
          if (rd_hs) begin
            rd_cnt <= rd_cnt + LEN_W'(1);
            if (rd_last) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered AIP-side outputs: write data/pulse, start pulse, config code
  // (held through IDLE) and the sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      aip_data_in  <= '0;
      aip_config   <= '0;
      aip_write    <= 1'b0;
      aip_start    <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      aip_write <= wr_hs;
      if (wr_hs) begin
        aip_data_in <= bus.i_wr_data;
      end
      aip_start <= (state == S_START) && !aip_start;
      if (state == S_CFG_IN) begin
        aip_config <= in_cfg;
      end else if (state == S_CFG_OUT) begin
        aip_config <= out_cfg;
      end
      if (cmd_accept) begin
        timeout_flag <= 1'b0;
      end else if (to_expire) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  // State-decoded status and stream controls; the read strobe follows the
  // consumer's ready directly so each ready cycle advances exactly one word.
  assign bus.o_cmd_ready  = (state == S_IDLE);
  assign bus.o_busy       = (state != S_IDLE);
  assign bus.o_wr_ready   = (state == S_LOAD);
  assign bus.o_rd_valid   = (state == S_DRAIN);
  assign bus.o_rd_data    = bus.i_aip_dataOut;
  assign bus.o_aip_read   = rd_hs;
  assign bus.o_done       = (state == S_DONE);
  assign bus.o_timeout    = timeout_flag;
  assign bus.o_aip_dataIn = aip_data_in;
  assign bus.o_aip_config = aip_config;
  assign bus.o_aip_write  = aip_write;
  assign bus.o_aip_start  = aip_start;

endmodule

// File: tb/tb_aip_sequencer.sv
// Directed bench for aip_sequencer, playing host, streams and AIP core.
module tb_aip_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  int wr_count = 0;
  int rd_count = 0;
  int start_count = 0;
  int done_count = 0;
  logic [31:0] rd_log [0:63];

  aip_sequencer_if #(.LEN_W(8)) bus ();

  aip_sequencer #(.LEN_W(8), .TIMEOUT_CYC(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Event tally sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.o_aip_write === 1'b1) wr_count++;
    if (bus.o_aip_read === 1'b1) begin
      rd_log[rd_count % 64] = bus.o_rd_data;
      rd_count++;
    end
    if (bus.o_aip_start === 1'b1) start_count++;
    if (bus.o_done === 1'b1) done_count++;
  end

  // Hard stop so a stuck run still reports.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_cmd_valid   = 1'b0;
    bus.i_cmd_in_len  = '0;
    bus.i_cmd_out_len = '0;
    bus.i_cmd_in_cfg  = '0;
    bus.i_cmd_out_cfg = '0;
    bus.i_wr_data     = '0;
    bus.i_wr_valid    = 1'b0;
    bus.i_rd_ready    = 1'b0;
    bus.i_aip_dataOut = '0;
    bus.i_aip_int     = 1'b0;
  endtask

  task automatic load_cmd(input logic [7:0] il, input logic [7:0] ol,
                          input logic [4:0] ic, input logic [4:0] oc);
    bus.i_cmd_valid   = 1'b1;
    bus.i_cmd_in_len  = il;
    bus.i_cmd_out_len = ol;
    bus.i_cmd_in_cfg  = ic;
    bus.i_cmd_out_cfg = oc;
  endtask

  task automatic test_reset();
    logic [8:0] flags;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    flags = {bus.o_cmd_ready, bus.o_busy, bus.o_done, bus.o_timeout, bus.o_wr_ready,
             bus.o_rd_valid, bus.o_aip_write, bus.o_aip_read, bus.o_aip_start};
    vectors++; if (flags !== 9'b1_0000_0000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b expected %b", flags, 9'b1_0000_0000); end
    vectors++; if (bus.o_aip_dataIn !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_dataIn: got %h expected %h", bus.o_aip_dataIn, 32'h0); end
    vectors++; if (bus.o_aip_config !== 5'h0) begin miscompares++; $display("[TB] FAIL reset_config: got %h expected %h", bus.o_aip_config, 5'h0); end
    vectors++; if (bus.o_rd_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rd_data: got %h expected %h", bus.o_rd_data, 32'h0); end
    tick();
    vectors++; if (bus.o_cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready_hold: got %b expected 1", bus.o_cmd_ready); end
  endtask

  task automatic test_nominal();
    int w0, r0, s0, d0;
    w0 = wr_count; r0 = rd_count; s0 = start_count; d0 = done_count;
    load_cmd(8'd3, 8'd2, 5'd1, 5'd2);
    #1;
    vectors++; if (bus.o_cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL nom_ready: got %b expected 1", bus.o_cmd_ready); end
    tick();
    bus.i_cmd_valid = 1'b0;
    #1;
    vectors++; if ({bus.o_busy, bus.o_cmd_ready, bus.o_wr_ready} !== 3'b100) begin miscompares++; $display("[TB] FAIL nom_cfg_in: got %b expected 100", {bus.o_busy, bus.o_cmd_ready, bus.o_wr_ready}); end
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_data  = 32'hA1 + i;
      #1;
      if (i == 0) begin
        vectors++; if (bus.o_aip_config !== 5'd1) begin miscompares++; $display("[TB] FAIL nom_in_cfg: got %0d expected 1", bus.o_aip_config); end
      end
      vectors++; if (bus.o_wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL nom_wr_ready[%0d]: got %b expected 1", i, bus.o_wr_ready); end
      tick();
      vectors++; if ({bus.o_aip_write, bus.o_aip_dataIn} !== {1'b1, 32'hA1 + i}) begin miscompares++; $display("[TB] FAIL nom_write[%0d]: got %b/%h expected 1/%h", i, bus.o_aip_write, bus.o_aip_dataIn, 32'hA1 + i); end
    end
    bus.i_wr_valid = 1'b0;
    #1;
    vectors++; if ({bus.o_aip_start, bus.o_wr_ready} !== 2'b00) begin miscompares++; $display("[TB] FAIL nom_pre_start: got %b expected 00", {bus.o_aip_start, bus.o_wr_ready}); end
    tick();
    vectors++; if ({bus.o_aip_start, bus.o_aip_write} !== 2'b10) begin miscompares++; $display("[TB] FAIL nom_start: got %b expected 10", {bus.o_aip_start, bus.o_aip_write}); end
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++; if ({bus.o_aip_start, bus.o_rd_valid, bus.o_busy} !== 3'b001) begin miscompares++; $display("[TB] FAIL nom_wait[%0d]: got %b expected 001", i, {bus.o_aip_start, bus.o_rd_valid, bus.o_busy}); end
      tick();
    end
    bus.i_aip_int = 1'b1;
    tick();
    bus.i_aip_int = 1'b0;
    #1;
    vectors++; if (bus.o_aip_config !== 5'd1) begin miscompares++; $display("[TB] FAIL nom_cfg_out_hold: got %0d expected 1", bus.o_aip_config); end
    tick();
    vectors++; if ({bus.o_aip_config, bus.o_rd_valid} !== {5'd2, 1'b0}) begin miscompares++; $display("[TB] FAIL nom_settle: got %0d/%b expected 2/0", bus.o_aip_config, bus.o_rd_valid); end
    bus.i_aip_dataOut = 32'hB1;
    tick();
    bus.i_rd_ready = 1'b1;
    #1;
    vectors++; if ({bus.o_rd_valid, bus.o_aip_read, bus.o_rd_data} !== {2'b11, 32'hB1}) begin miscompares++; $display("[TB] FAIL nom_read0: got %b%b/%h expected 11/b1", bus.o_rd_valid, bus.o_aip_read, bus.o_rd_data); end
    tick();
    bus.i_aip_dataOut = 32'hB2;
    #1;
    vectors++; if ({bus.o_rd_valid, bus.o_aip_read, bus.o_rd_data} !== {2'b11, 32'hB2}) begin miscompares++; $display("[TB] FAIL nom_read1: got %b%b/%h expected 11/b2", bus.o_rd_valid, bus.o_aip_read, bus.o_rd_data); end
    tick();
    bus.i_rd_ready = 1'b0;
    #1;
    vectors++; if ({bus.o_done, bus.o_timeout, bus.o_rd_valid} !== 3'b100) begin miscompares++; $display("[TB] FAIL nom_done: got %b expected 100", {bus.o_done, bus.o_timeout, bus.o_rd_valid}); end
    tick();
    vectors++; if ({bus.o_cmd_ready, bus.o_done, bus.o_busy} !== 3'b100) begin miscompares++; $display("[TB] FAIL nom_idle: got %b expected 100", {bus.o_cmd_ready, bus.o_done, bus.o_busy}); end
    vectors++; if ((wr_count - w0) != 3 || (rd_count - r0) != 2 || (start_count - s0) != 1 || (done_count - d0) != 1) begin miscompares++; $display("[TB] FAIL nom_tally: got w%0d r%0d s%0d d%0d expected w3 r2 s1 d1", wr_count - w0, rd_count - r0, start_count - s0, done_count - d0); end
  endtask

  task automatic test_backpressure();
    logic [4:0] pat;
    int w0, r0;
    pat = 5'b10101;
    w0 = wr_count; r0 = rd_count;
    load_cmd(8'd3, 8'd2, 5'd3, 5'd4);
    tick();
    bus.i_cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_valid = pat[i];
      bus.i_wr_data  = 32'hC0 + i;
      #1;
      vectors++; if (bus.o_wr_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_wr_ready[%0d]: got %b expected 1", i, bus.o_wr_ready); end
      tick();
      vectors++; if (bus.o_aip_write !== pat[i]) begin miscompares++; $display("[TB] FAIL bp_write[%0d]: got %b expected %b", i, bus.o_aip_write, pat[i]); end
    end
    bus.i_wr_valid = 1'b0;
    tick();
    tick();
    bus.i_aip_int = 1'b1;
    tick();
    bus.i_aip_int = 1'b0;
    tick();
    bus.i_aip_dataOut = 32'hD1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if ({bus.o_rd_valid, bus.o_aip_read, bus.o_rd_data} !== {2'b10, 32'hD1}) begin miscompares++; $display("[TB] FAIL bp_stall[%0d]: got %b%b/%h expected 10/d1", i, bus.o_rd_valid, bus.o_aip_read, bus.o_rd_data); end
      tick();
    end
    bus.i_rd_ready = 1'b1;
    tick();
    bus.i_aip_dataOut = 32'hD2;
    tick();
    bus.i_rd_ready = 1'b0;
    #1;
    vectors++; if (bus.o_done !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_done: got %b expected 1", bus.o_done); end
    vectors++; if ((wr_count - w0) != 3 || (rd_count - r0) != 2) begin miscompares++; $display("[TB] FAIL bp_tally: got w%0d r%0d expected w3 r2", wr_count - w0, rd_count - r0); end
    vectors++; if (rd_log[r0 % 64] !== 32'hD1 || rd_log[(r0 + 1) % 64] !== 32'hD2) begin miscompares++; $display("[TB] FAIL bp_words: got %h %h expected d1 d2", rd_log[r0 % 64], rd_log[(r0 + 1) % 64]); end
    tick();
  endtask

  task automatic test_zero_len();
    int w0, r0, s0;
    w0 = wr_count; r0 = rd_count; s0 = start_count;
    load_cmd(8'd0, 8'd0, 5'd5, 5'd6);
    bus.i_wr_valid = 1'b1;
    bus.i_rd_ready = 1'b1;
    tick();
    bus.i_cmd_valid = 1'b0;
    tick();
    vectors++; if ({bus.o_aip_start, bus.o_wr_ready, bus.o_aip_config} !== {2'b00, 5'd5}) begin miscompares++; $display("[TB] FAIL zero_t2: got %b%b/%0d expected 00/5", bus.o_aip_start, bus.o_wr_ready, bus.o_aip_config); end
    tick();
    vectors++; if (bus.o_aip_start !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_start_t3: got %b expected 1", bus.o_aip_start); end
    tick();
    tick();
    bus.i_aip_int = 1'b1;
    tick();
    bus.i_aip_int = 1'b0;
    tick();
    vectors++; if ({bus.o_aip_config, bus.o_done} !== {5'd6, 1'b0}) begin miscompares++; $display("[TB] FAIL zero_settle: got %0d/%b expected 6/0", bus.o_aip_config, bus.o_done); end
    tick();
    vectors++; if ({bus.o_done, bus.o_rd_valid} !== 2'b10) begin miscompares++; $display("[TB] FAIL zero_done: got %b expected 10", {bus.o_done, bus.o_rd_valid}); end
    bus.i_wr_valid = 1'b0;
    bus.i_rd_ready = 1'b0;
    tick();
    vectors++; if ((wr_count - w0) != 0 || (rd_count - r0) != 0 || (start_count - s0) != 1) begin miscompares++; $display("[TB] FAIL zero_tally: got w%0d r%0d s%0d expected w0 r0 s1", wr_count - w0, rd_count - r0, start_count - s0); end
  endtask

  task automatic test_timeout();
    int r0;
    logic seen;
    r0 = rd_count;
    seen = 1'b0;
    load_cmd(8'd0, 8'd1, 5'd7, 5'd8);
    bus.i_rd_ready = 1'b1;
    tick();
    bus.i_cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      vectors++; if ({bus.o_done, bus.o_timeout, bus.o_busy} !== 3'b001) begin miscompares++; $display("[TB] FAIL to_wait[%0d]: got %b expected 001", i, {bus.o_done, bus.o_timeout, bus.o_busy}); end
      tick();
    end
    vectors++; if ({bus.o_done, bus.o_timeout, bus.o_rd_valid, bus.o_aip_config} !== {3'b110, 5'd7}) begin miscompares++; $display("[TB] FAIL to_expire: got %b/%0d expected 110/7", {bus.o_done, bus.o_timeout, bus.o_rd_valid}, bus.o_aip_config); end
    tick();
    load_cmd(8'd0, 8'd0, 5'd11, 5'd12);
    #1;
    vectors++; if ({bus.o_cmd_ready, bus.o_timeout} !== 2'b11) begin miscompares++; $display("[TB] FAIL to_sticky: got %b expected 11", {bus.o_cmd_ready, bus.o_timeout}); end
    vectors++; if ((rd_count - r0) != 0) begin miscompares++; $display("[TB] FAIL to_no_reads: got %0d expected 0", rd_count - r0); end
    tick();
    bus.i_cmd_valid = 1'b0;
    bus.i_aip_int = 1'b1;
    #1;
    vectors++; if (bus.o_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL to_clear: got %b expected 0", bus.o_timeout); end
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (bus.o_done === 1'b1) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("[TB] FAIL to_followup_done: got %b expected 1", seen); end
    bus.i_aip_int = 1'b0;
    bus.i_rd_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_load();
    int w0, s0;
    logic [8:0] flags;
    w0 = wr_count; s0 = start_count;
    load_cmd(8'd3, 8'd1, 5'd9, 5'd10);
    tick();
    bus.i_cmd_valid = 1'b0;
    tick();
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = 32'hE1;
    tick();
    bus.i_wr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    flags = {bus.o_cmd_ready, bus.o_busy, bus.o_done, bus.o_timeout, bus.o_wr_ready,
             bus.o_rd_valid, bus.o_aip_write, bus.o_aip_read, bus.o_aip_start};
    vectors++; if (flags !== 9'b1_0000_0000) begin miscompares++; $display("[TB] FAIL rml_flags: got %b expected %b", flags, 9'b1_0000_0000); end
    vectors++; if ({bus.o_aip_dataIn, bus.o_aip_config} !== 37'h0) begin miscompares++; $display("[TB] FAIL rml_regs: got %h/%h expected 0/0", bus.o_aip_dataIn, bus.o_aip_config); end
    bus.i_wr_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bus.i_wr_valid = 1'b0;
    vectors++; if ((wr_count - w0) != 1 || (start_count - s0) != 0) begin miscompares++; $display("[TB] FAIL rml_tally: got w%0d s%0d expected w1 s0", wr_count - w0, start_count - s0); end
  endtask

  task automatic test_ignored_inputs();
    int d0;
    d0 = done_count;
    load_cmd(8'd1, 8'd1, 5'd9, 5'd10);
    tick();
    load_cmd(8'd5, 8'd3, 5'd13, 5'd14);
    #1;
    vectors++; if (bus.o_cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_ready_busy: got %b expected 0", bus.o_cmd_ready); end
    tick();
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = 32'hE5;
    tick();
    bus.i_wr_valid = 1'b0;
    #1;
    vectors++; if ({bus.o_aip_write, bus.o_wr_ready} !== 2'b10) begin miscompares++; $display("[TB] FAIL ign_len_latched: got %b expected 10", {bus.o_aip_write, bus.o_wr_ready}); end
    tick();
    bus.i_aip_int = 1'b1;
    #1;
    vectors++; if (bus.o_aip_start !== 1'b1) begin miscompares++; $display("[TB] FAIL ign_start: got %b expected 1", bus.o_aip_start); end
    tick();
    bus.i_aip_int = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if ({bus.o_aip_config, bus.o_rd_valid, bus.o_busy} !== {5'd9, 2'b01}) begin miscompares++; $display("[TB] FAIL ign_wait[%0d]: got %0d/%b%b expected 9/01", i, bus.o_aip_config, bus.o_rd_valid, bus.o_busy); end
      tick();
    end
    bus.i_aip_int = 1'b1;
    tick();
    bus.i_aip_int = 1'b0;
    tick();
    vectors++; if (bus.o_aip_config !== 5'd10) begin miscompares++; $display("[TB] FAIL ign_out_cfg: got %0d expected 10", bus.o_aip_config); end
    bus.i_aip_dataOut = 32'hF1;
    tick();
    bus.i_rd_ready = 1'b1;
    tick();
    bus.i_rd_ready = 1'b0;
    #1;
    vectors++; if ({bus.o_done, bus.o_cmd_ready} !== 2'b10) begin miscompares++; $display("[TB] FAIL ign_done: got %b expected 10", {bus.o_done, bus.o_cmd_ready}); end
    tick();
    vectors++; if (bus.o_cmd_ready !== 1'b1 || (done_count - d0) != 1) begin miscompares++; $display("[TB] FAIL ign_after_done: got ready %b dones %0d expected 1/1", bus.o_cmd_ready, done_count - d0); end
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    $display("[TB] aip_sequencer directed bench");
    test_reset();
    test_nominal();
    test_backpressure();
    test_zero_len();
    test_timeout();
    test_reset_mid_load();
    test_ignored_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
